// File: rtl/md_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes, FSM states, decode helpers.
package md_pkg;

  typedef enum logic [2:0] {
    OpMult  = 3'd0,
    OpMultu = 3'd1,
    OpMadd  = 3'd2,
    OpMaddu = 3'd3,
    OpMsub  = 3'd4,
    OpMsubu = 3'd5,
    OpDiv   = 3'd6,
    OpDivu  = 3'd7
  } md_op_e;

  typedef enum logic [2:0] {
    StIdle,
    StMul,
    StAcc,
    StDiv,
    StFix,
    StDone
  } md_state_e;

  // Even op codes are the signed variants.
  function automatic logic is_signed(md_op_e op);
    return ~op[0];
  endfunction

  function automatic logic is_acc(md_op_e op);
    return (op == OpMadd) || (op == OpMaddu) || (op == OpMsub) || (op == OpMsubu);
  endfunction

  function automatic logic is_sub(md_op_e op);
    return (op == OpMsub) || (op == OpMsubu);
  endfunction

  function automatic logic is_div(md_op_e op);
    return (op == OpDiv) || (op == OpDivu);
  endfunction

endpackage

// File: rtl/md_div_iter.sv
// Restoring unsigned divider core: one quotient bit per step, WIDTH steps after load.
module md_div_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quot_o,
  output logic [WIDTH-1:0] rem_o,
  output logic             finished_o
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] quot_q, rem_q, div_q;
  logic [WIDTH-1:0] quot_d, rem_d;
  logic [WIDTH:0]   shifted, diff;

  // One restoring step: shift in next dividend bit, subtract if it fits.
  always_comb begin
    shifted = {rem_q, quot_q[WIDTH-1]};
    diff    = shifted - {1'b0, div_q};
    // rem < divisor is invariant, so bit WIDTH of diff is a clean borrow flag.
    if (!diff[WIDTH]) begin
      rem_d  = diff[WIDTH-1:0];
      quot_d = {quot_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_d  = shifted[WIDTH-1:0];
      quot_d = {quot_q[WIDTH-2:0], 1'b0};
    end
  end

  // Iteration state; the quotient register doubles as the dividend shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      div_q  <= '0;
    end else if (load_i) begin
      cnt_q  <= '0;
      quot_q <= dividend_i;
      rem_q  <= '0;
      div_q  <= divisor_i;
    end else if (step_i && !finished_o) begin
      cnt_q  <= cnt_q + CntW'(1);
      quot_q <= quot_d;
      rem_q  <= rem_d;
    end
  end

  assign finished_o = (cnt_q == CntW'(WIDTH));
  assign quot_o     = quot_q;
  assign rem_o      = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle HI/LO unit: mult/madd/msub via a registered product, div via md_div_iter.
module muldiv_unit
  import md_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] op1_i,
  input  logic [WIDTH-1:0] op2_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic             annul_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div_zero_o
);

  md_state_e          state_q;
  md_op_e             op_q;
  logic [WIDTH-1:0]   op1_q, op2_q, hi_q, lo_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH-1:0]   res_hi_q, res_lo_q;
  logic               done_q, dz_q;

  md_op_e             op_in;
  logic               in_zero, accept, div_load, div_step, div_fin;
  logic [WIDTH-1:0]   abs1, abs2, div_quot, div_rem;
  logic [2*WIDTH-1:0] ext1, ext2, prod, acc_sum;
  logic               q_neg, r_neg;
  logic [WIDTH-1:0]   fix_q, fix_r;

  assign op_in   = md_op_e'(op_i);
  assign in_zero = (op2_i == '0);
  assign accept  = (state_q == StIdle) && start_i && !annul_i;

  // Divider operands are made absolute at accept so the core loads straight from the inputs.
  always_comb begin
    abs1 = (is_signed(op_in) && op1_i[WIDTH-1]) ? (~op1_i + WIDTH'(1)) : op1_i;
    abs2 = (is_signed(op_in) && op2_i[WIDTH-1]) ? (~op2_i + WIDTH'(1)) : op2_i;
  end

  assign div_load = accept && is_div(op_in) && !in_zero;
  assign div_step = (state_q == StDiv) && !div_fin && !annul_i;

  md_div_iter #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .load_i    (div_load),
    .step_i    (div_step),
    .dividend_i(abs1),
    .divisor_i (abs2),
    .quot_o    (div_quot),
    .rem_o     (div_rem),
    .finished_o(div_fin)
  );

  // Product (sign/zero extended to 2*WIDTH, truncated) and accumulate on the latched operands.
  always_comb begin
    ext1    = {{WIDTH{is_signed(op_q) & op1_q[WIDTH-1]}}, op1_q};
    ext2    = {{WIDTH{is_signed(op_q) & op2_q[WIDTH-1]}}, op2_q};
    prod    = ext1 * ext2;
    acc_sum = is_sub(op_q) ? ({hi_q, lo_q} - prod_q) : ({hi_q, lo_q} + prod_q);
  end

  // Sign fix-up of the unsigned divider result; MIN_INT / -1 wraps back to MIN_INT naturally.
  always_comb begin
    q_neg = is_signed(op_q) & (op1_q[WIDTH-1] ^ op2_q[WIDTH-1]);
    r_neg = is_signed(op_q) & op1_q[WIDTH-1];
    fix_q = q_neg ? (~div_quot + WIDTH'(1)) : div_quot;
    fix_r = r_neg ? (~div_rem + WIDTH'(1)) : div_rem;
  end

  // Control FSM with registered results; annul drops everything without touching hi/lo.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= OpMult;
      op1_q    <= '0;
      op2_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      prod_q   <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else if (annul_i) begin
      state_q <= StIdle;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            op_q  <= op_in;
            op1_q <= op1_i;
            op2_q <= op2_i;
            hi_q  <= hi_i;
            lo_q  <= lo_i;
            if (is_div(op_in)) begin
              if (in_zero) begin
                res_hi_q <= op1_i;
                res_lo_q <= '1;
                dz_q     <= 1'b1;
                done_q   <= 1'b1;
                state_q  <= StDone;
              end else begin
                state_q <= StDiv;
              end
            end else begin
              state_q <= StMul;
            end
          end
        end
        StMul: begin
          prod_q <= prod;
          if (is_acc(op_q)) begin
            state_q <= StAcc;
          end else begin
            {res_hi_q, res_lo_q} <= prod;
            dz_q    <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StAcc: begin
          {res_hi_q, res_lo_q} <= acc_sum;
          dz_q    <= 1'b0;
          done_q  <= 1'b1;
          state_q <= StDone;
        end
        StDiv: begin
          if (div_fin) state_q <= StFix;
        end
        StFix: begin
          res_hi_q <= fix_r;
          res_lo_q <= fix_q;
          dz_q     <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= StDone;
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o     = (state_q != StIdle);
  assign done_o     = done_q;
  assign hi_o       = res_hi_q;
  assign lo_o       = res_lo_q;
  assign div_zero_o = dz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table through a scoreboard plus corner sequences.
module tb_muldiv_unit;
  import md_pkg::*;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start, annul;
  logic [2:0]   op;
  logic [W-1:0] op1, op2, hi_in, lo_in;
  logic         busy, done, dz;
  logic [W-1:0] hi, lo;

  muldiv_unit #(.WIDTH(W)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start),
    .op_i      (op),
    .op1_i     (op1),
    .op2_i     (op2),
    .hi_i      (hi_in),
    .lo_i      (lo_in),
    .annul_i   (annul),
    .busy_o    (busy),
    .done_o    (done),
    .hi_o      (hi),
    .lo_o      (lo),
    .div_zero_o(dz)
  );

  logic       start8, annul8;
  logic [2:0] op8;
  logic [7:0] a8, b8, hi8_in, lo8_in, hi8, lo8;
  logic       busy8, done8, dz8;

  muldiv_unit #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start8),
    .op_i      (op8),
    .op1_i     (a8),
    .op2_i     (b8),
    .hi_i      (hi8_in),
    .lo_i      (lo8_in),
    .annul_i   (annul8),
    .busy_o    (busy8),
    .done_o    (done8),
    .hi_o      (hi8),
    .lo_o      (lo8),
    .div_zero_o(dz8)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           issue;
    int           lat;
    string        name;
  } exp_t;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] h;
    logic [W-1:0] l;
    logic [W-1:0] ehi;
    logic [W-1:0] elo;
    logic         edz;
    int           lat;
    string        name;
  } vec_t;

  exp_t sb[$];
  exp_t e;
  vec_t vt[13];

  // Scoreboard: every done_o pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done: done_o=1 at cycle %0d, required no done", cyc);
      end else begin
        e = sb.pop_front();
        if (hi !== e.hi || lo !== e.lo || dz !== e.dz || (cyc - e.issue) != e.lat) begin
          fails++;
          $display("FAIL %s: got hi=%h lo=%h dz=%b lat=%0d, required hi=%h lo=%h dz=%b lat=%0d",
                   e.name, hi, lo, dz, cyc - e.issue, e.hi, e.lo, e.dz, e.lat);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    if (busy) begin
      tests++;
      fails++;
      $display("FAIL wait_idle: busy_o=1 after %0d cycles, required 0", n);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  // Drive one request; operands are scrambled afterwards to prove they were latched.
  task automatic issue(input vec_t v, input logic push);
    exp_t x;
    wait_idle();
    op    = v.op;
    op1   = v.a;
    op2   = v.b;
    hi_in = v.h;
    lo_in = v.l;
    start = 1'b1;
    if (push) begin
      x.hi = v.ehi; x.lo = v.elo; x.dz = v.edz; x.issue = cyc; x.lat = v.lat; x.name = v.name;
      sb.push_back(x);
    end
    tick();
    start = 1'b0;
    op1   = $urandom;
    op2   = $urandom;
    hi_in = $urandom;
    lo_in = $urandom;
    check({v.name, "_busy"}, 64'(busy), 64'd1);
  endtask

  initial begin
    vec_t v;
    int n, d0, k;

    vt[0]  = '{OpMult,  32'hFFFFFFFE, 32'd3, 32'h0, 32'h0,
               32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, 2, "mult_neg"};
    vt[1]  = '{OpMultu, 32'hFFFFFFFE, 32'd3, 32'h0, 32'h0,
               32'h00000002, 32'hFFFFFFFA, 1'b0, 2, "multu"};
    vt[2]  = '{OpMadd,  32'd1, 32'd1, 32'h0, 32'hFFFFFFFF,
               32'h00000001, 32'h00000000, 1'b0, 3, "madd_carry"};
    vt[3]  = '{OpMsubu, 32'd1, 32'd1, 32'h0, 32'h0,
               32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 3, "msubu_wrap"};
    vt[4]  = '{OpDiv,   32'hFFFFFFF9, 32'd2, 32'h0, 32'h0,
               32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 35, "div_m7_2"};
    vt[5]  = '{OpDivu,  32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h0,
               32'h80000000, 32'h00000000, 1'b0, 35, "divu_big"};
    vt[6]  = '{OpDiv,   32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h0,
               32'h00000000, 32'h80000000, 1'b0, 35, "div_minint"};
    vt[7]  = '{OpDivu,  32'd5, 32'd0, 32'h0, 32'h0,
               32'h00000005, 32'hFFFFFFFF, 1'b1, 1, "divu_zero"};
    vt[8]  = '{OpDiv,   32'd7, 32'hFFFFFFFE, 32'h0, 32'h0,
               32'h00000001, 32'hFFFFFFFD, 1'b0, 35, "div_7_m2"};
    vt[9]  = '{OpMsub,  32'd3, 32'd4, 32'h0, 32'd10,
               32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 3, "msub_neg"};
    vt[10] = '{OpMaddu, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 32'h0,
               32'hFFFFFFFF, 32'h00000001, 1'b0, 3, "maddu_big"};
    vt[11] = '{OpDiv,   32'hFFFFFFF8, 32'd0, 32'h0, 32'h0,
               32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1, 1, "div_zero_s"};
    vt[12] = '{OpMult,  32'hFFFFFFFD, 32'hFFFFFFFB, 32'h0, 32'h0,
               32'h00000000, 32'h0000000F, 1'b0, 2, "mult_negneg"};

    rst = 1'b1; start = 1'b0; annul = 1'b0; op = '0;
    op1 = '0; op2 = '0; hi_in = '0; lo_in = '0;
    start8 = 1'b0; annul8 = 1'b0; op8 = '0; a8 = '0; b8 = '0; hi8_in = '0; lo8_in = '0;
    repeat (3) tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_dz", 64'(dz), 64'd0);
    rst = 1'b0;
    tick();

    // Table, issued back-to-back as soon as busy_o drops.
    for (int i = 0; i < 13; i++) issue(vt[i], 1'b1);
    drain();
    tick();

    // Annul during a divide: no done, result registers keep the last result.
    v = '{OpDiv, 32'd100, 32'd7, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 35, "annul_div"};
    issue(v, 1'b0);
    repeat (9) tick();
    annul = 1'b1;
    tick();
    annul = 1'b0;
    check("annul_busy", 64'(busy), 64'd0);
    repeat (40) tick();
    check("annul_hi_kept", 64'(hi), 64'(vt[12].ehi));
    check("annul_lo_kept", 64'(lo), 64'(vt[12].elo));

    // Annul together with start: request dropped.
    op = OpMult; op1 = 32'd2; op2 = 32'd3;
    start = 1'b1; annul = 1'b1;
    tick();
    start = 1'b0; annul = 1'b0;
    check("annul_start_busy", 64'(busy), 64'd0);
    repeat (4) tick();
    check("annul_start_idle", 64'(busy), 64'd0);

    // start_i held high through a divide: exactly one completion.
    wait_idle();
    op = OpDivu; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
    e.hi = 32'd2; e.lo = 32'd14; e.dz = 1'b0; e.issue = cyc; e.lat = 35; e.name = "held_start";
    sb.push_back(e);
    d0 = done_cnt;
    n = 0;
    tick();
    while (!done && n < 100) begin
      tick();
      n++;
    end
    start = 1'b0;
    check("held_done_seen", 64'(done), 64'd1);
    repeat (40) tick();
    check("held_one_done", 64'(done_cnt - d0), 64'd1);
    drain();

    // Reset in the middle of a divide aborts it and clears the outputs.
    v = '{OpDiv, 32'd1000, 32'd3, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 35, "rst_div"};
    issue(v, 1'b0);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_hi", 64'(hi), 64'd0);
    check("midrst_lo", 64'(lo), 64'd0);
    check("midrst_dz", 64'(dz), 64'd0);
    rst = 1'b0;
    repeat (40) tick();

    // Narrow build: DIVU 200/7 completes WIDTH+3 cycles after accept.
    op8 = OpDivu; a8 = 8'd200; b8 = 8'd7; start8 = 1'b1;
    k = cyc;
    tick();
    start8 = 1'b0; a8 = 8'hA5; b8 = 8'h00;
    n = 0;
    while (!done8 && n < 50) begin
      tick();
      n++;
    end
    check("w8_done", 64'(done8), 64'd1);
    check("w8_lat", 64'(cyc - k), 64'd11);
    check("w8_lo", 64'(lo8), 64'd28);
    check("w8_hi", 64'(hi8), 64'd4);
    check("w8_dz", 64'(dz8), 64'd0);

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised multi-cycle HI/LO arithmetic unit for the MIPS integer pipeline, next to the EX stage. It executes mult/multu, madd/maddu/msub/msubu and div/divu from one start/done handshake and owns its own iteration counter. It supports cancellation from the pipeline (annul) and selectable operand width. EX holds the pipeline stalled while busy_o is high and writes hi_o/lo_o to HI/LO on done_o.

## Interface
- WIDTH, 32: operand width; HI/LO each WIDTH bits, product 2*WIDTH.
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start_i  in  1  request; sampled only when busy_o=0.
- op_i  in  3  operation code (md_pkg).
- op1_i  in  WIDTH  rs operand (multiplicand / dividend).
- op2_i  in  WIDTH  rt operand (multiplier / divisor).
- hi_i, lo_i  in  WIDTH each  current HI/LO, accumulator source for madd/msub.
- annul_i  in  1  cancel current or requested operation.
- busy_o  out  1  operation in flight.
- done_o  out  1  one-cycle pulse, hi_o/lo_o valid.
- hi_o, lo_o  out  WIDTH each  result; held until the next done_o.
- div_zero_o  out  1  valid with done_o: divisor was zero.

## Operation
- Op codes: MULT=0, MULTU=1, MADD=2, MADDU=3, MSUB=4, MSUBU=5, DIV=6, DIVU=7.
- On an accepted start, latch op, op1, op2, hi_i and lo_i. Later changes on those inputs are ignored.
- FSM states: IDLE, MUL, ACC, DIV, FIX, DONE.
- Transitions:
  - IDLE -> MUL for mult/madd/msub.
  - IDLE -> DIV for div/divu with op2≠0.
  - IDLE -> DONE for div/divu with op2=0.
- MUL: register the 2*WIDTH product, signed for even codes and unsigned for odd codes. Go to ACC for madd/msub, else to DONE.
- ACC: {hi,lo} ± product, mod 2^(2*WIDTH). Go to DONE.
- DIV: restoring, one quotient bit per cycle, WIDTH cycles counted by a $clog2(WIDTH+1)-bit counter. Then go to FIX.
  - Signed operations iterate on absolute values.
- FIX:
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Result: lo=quotient, hi=remainder.
  - MIN_INT / -1 gives lo=MIN_INT, hi=0, with no flag.
- Divide by zero: lo=all-ones, hi=op1, div_zero_o=1.
- DONE: drive done_o=1 and update hi_o/lo_o. Return to IDLE.
- busy_o=1 in every state except IDLE.
- annul_i=1 in any state: next state is IDLE, no done_o is produced, and hi_o/lo_o are unchanged.
  - annul_i together with start_i: annul wins and the request is dropped.
- start_i while busy_o=1: ignored, not queued.

## Timing
- Cycle k is the cycle in which start_i is accepted. busy_o rises at k+1.
- done_o is high in these cycles:
  - mult/multu: k+2.
  - madd/msub family: k+3.
  - div/divu: k+WIDTH+3.
  - divide by zero: k+1.
- busy_o is low in the cycle after done_o. A new start is accepted in that cycle, giving back-to-back issue.
- Reset values: state IDLE, busy_o=0, done_o=0, hi_o=0, lo_o=0, div_zero_o=0, counter 0.
- Reset mid-operation aborts the operation without producing done_o.
- div_zero_o is held with hi_o/lo_o.

## Structure
- Package md_pkg: op codes, the FSM state enum, and helpers is_signed(op) and is_acc(op).
- Sub-module md_div_iter: restoring divider core with load, step, count and finished, WIDTH-parametrised. The FSM, multiplier and accumulator stay in muldiv_unit.

## Test plan
- MULT with op1=0xFFFFFFFE and op2=3 -> done at k+2, hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands -> hi=0x2, lo=0xFFFFFFFA.
- MADD with hi_i=0, lo_i=0xFFFFFFFF, op1=1, op2=1 -> done at k+3, hi=1, lo=0. MSUBU with hi=lo=0, op1=op2=1 -> hi=lo=0xFFFFFFFF.
- DIV -7/2 -> done at k+35, lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 0x80000000/0xFFFFFFFF -> lo=0, hi=0x80000000. DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
- DIVU 5/0 -> done at k+1, div_zero_o=1, lo=0xFFFFFFFF, hi=5.
- annul_i pulsed at k+10 during DIV -> busy_o=0 at k+11, no done_o, hi_o/lo_o keep their prior values. annul_i and start_i in the same cycle -> no operation starts.
- start_i held high during a DIV -> exactly one done_o. rst at k+5 -> all outputs 0 next cycle. WIDTH=8 build: DIVU 200/7 -> done at k+11, lo=28, hi=4.
